// File: rtl/ct_lsu_amr_mstream.sv
// Multi-stream automatic memset recognizer: tracks up to NUM_STREAM sequential store streams
// seen at WMB pop and escalates each one toward write-allocate cancel and L2 memset.
module ct_lsu_amr_mstream #(
   parameter int PA_WIDTH   = 40,
   parameter int NUM_STREAM = 4,
   parameter int GRAN_BYTES = 16,
   parameter int CNT_WIDTH  = 6,
   parameter int TH_SET0    = 8,
   parameter int TH_SET1    = 16,
   parameter int TH_SET2    = 48,
   localparam int IDX_W     = (NUM_STREAM > 1) ? $clog2(NUM_STREAM) : 1
) (
   input  logic                    forever_cpuclk,
   input  logic                    cpurst,
   input  logic                    cp0_lsu_amr,
   input  logic                    cp0_lsu_amr2,
   input  logic                    cp0_lsu_no_op_req,
   input  logic                    icc_idle,
   input  logic                    wmb_ce_pop_vld,
   input  logic [PA_WIDTH-1:0]     wmb_ce_addr,
   input  logic [GRAN_BYTES-1:0]   wmb_ce_bytes_vld,
   input  logic                    wmb_ce_ca_st_inst,
   output logic                    amr_wa_cancel,
   output logic                    amr_l2_mem_set,
   output logic [IDX_W-1:0]        amr_hit_idx,
   output logic [3*NUM_STREAM-1:0] lsu_had_amr_state
);

   localparam int OFF_W = $clog2(GRAN_BYTES);
   localparam int TAG_W = PA_WIDTH - OFF_W;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] TH0      = CNT_WIDTH'(TH_SET0);
   localparam logic [CNT_WIDTH-1:0] TH1      = CNT_WIDTH'(TH_SET1);
   localparam logic [CNT_WIDTH-1:0] TH2      = CNT_WIDTH'(TH_SET2);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_STREAM - 1);

   typedef enum logic [2:0] {
      ST_JUDGE = 3'b000,
      ST_SET0  = 3'b001,
      ST_SET1  = 3'b011,
      ST_SET2  = 3'b111
   } amr_state_e;

   function automatic logic [2:0] step_down(input logic [2:0] s);
      case (s)
         ST_SET2: step_down = ST_SET1;
         ST_SET1: step_down = ST_SET0;
         ST_SET0: step_down = ST_JUDGE;
         default: step_down = ST_JUDGE;
      endcase
   endfunction

   function automatic logic [2:0] promote(input logic [2:0] s, input logic [CNT_WIDTH-1:0] c);
      case (s)
         ST_JUDGE: promote = (c >= TH0) ? ST_SET0 : ST_JUDGE;
         ST_SET0:  promote = (c >= TH1) ? ST_SET1 : ST_SET0;
         ST_SET1:  promote = (c >= TH2) ? ST_SET2 : ST_SET1;
         ST_SET2:  promote = ST_SET2;
         default:  promote = ST_JUDGE;
      endcase
   endfunction

   logic [NUM_STREAM-1:0] r_vld;
   logic [TAG_W-1:0]      r_tag   [NUM_STREAM];
   logic [GRAN_BYTES-1:0] r_bytes [NUM_STREAM];
   logic [CNT_WIDTH-1:0]  r_cnt   [NUM_STREAM];
   logic [2:0]            r_state [NUM_STREAM];
   logic [IDX_W-1:0]      r_ptr;
   logic [IDX_W-1:0]      r_hit_idx;

   logic [NUM_STREAM-1:0] w_vld_nxt;
   logic [TAG_W-1:0]      w_tag_nxt   [NUM_STREAM];
   logic [GRAN_BYTES-1:0] w_bytes_nxt [NUM_STREAM];
   logic [CNT_WIDTH-1:0]  w_cnt_nxt   [NUM_STREAM];
   logic [2:0]            w_state_nxt [NUM_STREAM];
   logic [TAG_W-1:0]      w_dist      [NUM_STREAM];
   logic [NUM_STREAM-1:0] w_full;
   logic [NUM_STREAM-1:0] w_hit;
   logic [TAG_W-1:0]      w_pop_tag;
   logic                  w_cancel;
   logic                  w_upd;
   logic                  w_any_hit;
   logic                  w_any_free;
   logic [IDX_W-1:0]      w_sel;
   logic [IDX_W-1:0]      w_free;
   logic [IDX_W-1:0]      w_victim;
   logic [IDX_W-1:0]      w_ptr_nxt;
   logic [IDX_W-1:0]      w_hit_idx_nxt;
   logic                  w_any_set2;
   logic                  w_unused_addr;

   assign w_unused_addr = ^wmb_ce_addr[OFF_W-1:0];

   // Hit detection, stream selection, victim choice and next-state for every stream
   always_comb begin
      w_pop_tag  = wmb_ce_addr[PA_WIDTH-1:OFF_W];
      w_cancel   = ~icc_idle | ~cp0_lsu_amr | cp0_lsu_no_op_req
                 | (wmb_ce_pop_vld & ~wmb_ce_ca_st_inst);
      w_upd      = wmb_ce_pop_vld & ~w_cancel;
      w_full     = {NUM_STREAM{1'b0}};
      w_hit      = {NUM_STREAM{1'b0}};
      w_any_hit  = 1'b0;
      w_any_free = 1'b0;
      w_sel      = {IDX_W{1'b0}};
      w_free     = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_STREAM; i++) begin
         w_full[i] = &r_bytes[i];
         w_dist[i] = w_pop_tag - r_tag[i];
         // a full granule chains to either neighbour; a partial one only merges in place
         if (w_full[i]) begin
            w_hit[i] = r_vld[i] & ((w_dist[i] == TAG_W'(1)) | (w_dist[i] == {TAG_W{1'b1}}));
         end else begin
            w_hit[i] = r_vld[i] & (w_dist[i] == {TAG_W{1'b0}});
         end
      end
      for (int i = NUM_STREAM - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_any_hit = 1'b1;
            w_sel     = IDX_W'(i);
         end else begin
            w_any_hit = w_any_hit;
         end
         if (!r_vld[i]) begin
            w_any_free = 1'b1;
            w_free     = IDX_W'(i);
         end else begin
            w_any_free = w_any_free;
         end
      end
      w_victim = w_any_free ? w_free : r_ptr;
      if (w_upd && !w_any_hit && !w_any_free) begin
         w_ptr_nxt = (r_ptr == LAST_IDX) ? {IDX_W{1'b0}} : r_ptr + IDX_W'(1);
      end else begin
         w_ptr_nxt = r_ptr;
      end
      if (w_upd) begin
         w_hit_idx_nxt = w_any_hit ? w_sel : w_victim;
      end else begin
         w_hit_idx_nxt = r_hit_idx;
      end
      for (int i = 0; i < NUM_STREAM; i++) begin
         w_vld_nxt[i]   = r_vld[i];
         w_tag_nxt[i]   = r_tag[i];
         w_bytes_nxt[i] = r_bytes[i];
         w_cnt_nxt[i]   = r_cnt[i];
         w_state_nxt[i] = promote(r_state[i], r_cnt[i]);
         if (w_cancel) begin
            w_vld_nxt[i]   = 1'b0;
            w_cnt_nxt[i]   = {CNT_WIDTH{1'b0}};
            w_state_nxt[i] = step_down(r_state[i]);
         end else if (w_upd && w_any_hit && (w_sel == IDX_W'(i))) begin
            w_tag_nxt[i] = w_pop_tag;
            if (w_full[i]) begin
               w_bytes_nxt[i] = wmb_ce_bytes_vld;
               w_cnt_nxt[i]   = (r_cnt[i] == CNT_MAX) ? CNT_MAX : r_cnt[i] + CNT_WIDTH'(1);
            end else if ((r_bytes[i] & wmb_ce_bytes_vld) != {GRAN_BYTES{1'b0}}) begin
               w_bytes_nxt[i] = wmb_ce_bytes_vld;
               w_cnt_nxt[i]   = {CNT_WIDTH{1'b0}};
               w_state_nxt[i] = step_down(r_state[i]);
            end else begin
               w_bytes_nxt[i] = r_bytes[i] | wmb_ce_bytes_vld;
            end
         end else if (w_upd && !w_any_hit && (w_victim == IDX_W'(i))) begin
            w_vld_nxt[i]   = 1'b1;
            w_tag_nxt[i]   = w_pop_tag;
            w_bytes_nxt[i] = wmb_ce_bytes_vld;
            w_cnt_nxt[i]   = {CNT_WIDTH{1'b0}};
            w_state_nxt[i] = ST_JUDGE;
         end else begin
            w_vld_nxt[i] = r_vld[i];
         end
      end
   end

   // Stream table, replacement pointer and last-hit index registers
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_vld     <= {NUM_STREAM{1'b0}};
         r_ptr     <= {IDX_W{1'b0}};
         r_hit_idx <= {IDX_W{1'b0}};
         for (int i = 0; i < NUM_STREAM; i++) begin
            r_tag[i]   <= {TAG_W{1'b0}};
            r_bytes[i] <= {GRAN_BYTES{1'b0}};
            r_cnt[i]   <= {CNT_WIDTH{1'b0}};
            r_state[i] <= ST_JUDGE;
         end
      end else begin
         r_vld     <= w_vld_nxt;
         r_ptr     <= w_ptr_nxt;
         r_hit_idx <= w_hit_idx_nxt;
         for (int i = 0; i < NUM_STREAM; i++) begin
            r_tag[i]   <= w_tag_nxt[i];
            r_bytes[i] <= w_bytes_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
            r_state[i] <= w_state_nxt[i];
         end
      end
   end

   // Aggregate per-stream state onto the request-path and HAD outputs
   always_comb begin
      amr_wa_cancel     = 1'b0;
      w_any_set2        = 1'b0;
      lsu_had_amr_state = {(3*NUM_STREAM){1'b0}};
      for (int i = 0; i < NUM_STREAM; i++) begin
         amr_wa_cancel              = amr_wa_cancel | r_state[i][0];
         w_any_set2                 = w_any_set2 | r_state[i][2];
         lsu_had_amr_state[3*i +: 3] = r_state[i];
      end
      amr_l2_mem_set = w_any_set2 & cp0_lsu_amr2;
      amr_hit_idx    = r_hit_idx;
   end

endmodule
